// File: rtl/pipe_stage_reg.sv
// Pipeline stage register (EX/MEM style) carrying control bits, destination address and payload.
// Latency: 1 cycle from input transfer to out_valid_o when the stage is empty.
// Backpressure: holds output stable while out_ready_i is low; in_ready_o drops when no slot is free.
//
// Configuration macro: PIPE_STAGE_SKID_EN
//   defined   -> two-entry skid buffer (EMPTY/ONE/TWO), in_ready_o driven from a flop
//   undefined -> single entry (EMPTY/ONE), in_ready_o = !out_valid_o || out_ready_i
//
// Ports:
//   clk_i, rst_i          clock and asynchronous active-high reset
//   flush_i               kill stored entries and any same-cycle input transfer
//   in_valid_i/in_ready_o upstream handshake; in_ctrl_i, in_addr_i, in_data_i entry fields
//   out_valid_o/out_ready_i downstream handshake; out_ctrl_o, out_addr_o, out_data_o entry fields

module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4,
    parameter int ADDR_W = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [CTRL_W-1:0]   in_ctrl_i,
    input  logic [ADDR_W-1:0]   in_addr_i,
    input  logic [2*DATA_W-1:0] in_data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [CTRL_W-1:0]   out_ctrl_o,
    output logic [ADDR_W-1:0]   out_addr_o,
    output logic [2*DATA_W-1:0] out_data_o
);

    logic                in_fire;
    logic                out_fire;
    logic                load_main_in;
    logic [CTRL_W-1:0]   main_ctrl;
    logic [ADDR_W-1:0]   main_addr;
    logic [2*DATA_W-1:0] main_data;

    assign in_fire  = in_valid_i && in_ready_o;
    assign out_fire = out_valid_o && out_ready_i;

`ifdef PIPE_STAGE_SKID_EN

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                ready_q;
    logic                load_main_skid;
    logic                load_skid;
    logic [CTRL_W-1:0]   skid_ctrl;
    logic [ADDR_W-1:0]   skid_addr;
    logic [2*DATA_W-1:0] skid_data;

    // Ready is computed from the next state and registered, so it never
    // depends combinationally on out_ready_i.
    assign in_ready_o  = ready_q;
    assign out_valid_o = (state_q != ST_EMPTY);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != ST_TWO);
        end
    end

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d      = ST_ONE;
                        load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        state_d   = ST_TWO;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready_o is low here, so only the drain path applies.
                    if (out_fire) begin
                        state_d        = ST_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            skid_ctrl <= '0;
            skid_addr <= '0;
            skid_data <= '0;
        end else if (load_skid) begin
            skid_ctrl <= in_ctrl_i;
            skid_addr <= in_addr_i;
            skid_data <= in_data_i;
        end
    end

`else

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_ONE   = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    assign out_valid_o = (state_q == ST_ONE);
    assign in_ready_o  = !out_valid_o || out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        load_main_in = 1'b0;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d      = ST_ONE;
                        load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire) begin
                        load_main_in = 1'b1;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_ctrl <= '0;
            main_addr <= '0;
            main_data <= '0;
        end else if (load_main_in) begin
            main_ctrl <= in_ctrl_i;
            main_addr <= in_addr_i;
            main_data <= in_data_i;
`ifdef PIPE_STAGE_SKID_EN
        end else if (load_main_skid) begin
            main_ctrl <= skid_ctrl;
            main_addr <= skid_addr;
            main_data <= skid_data;
`endif
        end
    end

    // A bubble must never carry write enables downstream, even if stale
    // contents remain in the holding register after a flush.
    assign out_ctrl_o = out_valid_o ? main_ctrl : '0;
    assign out_addr_o = main_addr;
    assign out_data_o = main_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 4;
    localparam int ADDR_W = 5;
    localparam int EW     = CTRL_W + ADDR_W + 2 * DATA_W;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                flush = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [CTRL_W-1:0]   in_ctrl = '0;
    logic [ADDR_W-1:0]   in_addr = '0;
    logic [2*DATA_W-1:0] in_data = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [CTRL_W-1:0]   out_ctrl;
    logic [ADDR_W-1:0]   out_addr;
    logic [2*DATA_W-1:0] out_data;

    int errors = 0;
    int checks = 0;
    int rst_cnt = 0;
    logic [EW-1:0] q[$];

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .ADDR_W(ADDR_W)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (flush),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_ctrl_i  (in_ctrl),
        .in_addr_i  (in_addr),
        .in_data_i  (in_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_ctrl_o (out_ctrl),
        .out_addr_o (out_addr),
        .out_data_o (out_data)
    );

    always #5 clk = ~clk;

    always @(posedge rst) rst_cnt++;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: samples on the falling edge, where inputs (driven
    // just after the rising edge) and DUT outputs are both settled.
    initial begin : monitor
        int            seen_rst = 0;
        logic          hold_vld = 1'b0;
        logic [EW-1:0] hold_val = '0;
        logic [EW-1:0] cur;
        logic [EW-1:0] exp;
        forever begin
            @(negedge clk);
            if (rst_cnt != seen_rst) begin
                q.delete();
                hold_vld = 1'b0;
                seen_rst = rst_cnt;
            end
            cur = {out_ctrl, out_addr, out_data};
            chk("out_valid_vs_occupancy", out_valid, q.size() != 0);
`ifdef PIPE_STAGE_SKID_EN
            chk("in_ready_skid", in_ready, q.size() < 2);
`else
            chk("in_ready_single", in_ready, (q.size() == 0) || out_ready);
`endif
            if (!out_valid) chk("bubble_ctrl_zero", out_ctrl, 0);
            if (hold_vld && out_valid) chk("stall_stable", cur, hold_val);
            if (rst || flush) begin
                q.delete();
                hold_vld = 1'b0;
            end else begin
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_output", cur, 0);
                    end else begin
                        exp = q.pop_front();
                        chk("output_entry", cur, exp);
                    end
                end
                if (in_valid && in_ready) q.push_back({in_ctrl, in_addr, in_data});
                hold_vld = out_valid && !out_ready;
                hold_val = cur;
            end
        end
    end

    task automatic set_entry(input int n);
        in_ctrl = n[CTRL_W-1:0];
        in_addr = n[ADDR_W-1:0] ^ 5'h15;
        in_data = {32'(n) + 32'h100, 32'(n)};
    endtask

    // Offer the current in_* fields until accepted (bounded).
    task automatic send_cur();
        logic acc = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        chk("send_accepted", acc, 1);
        in_valid = 1'b0;
    endtask

    // Stream entries first..first+count-1; out_ready low on cycles lo..hi (1-based).
    task automatic stream(input int first, input int count, input int lo, input int hi,
                          output int cyc);
        int idx = 0;
        logic acc;
        cyc = 0;
        while (idx < count && cyc < 100) begin
            cyc++;
            out_ready = !(cyc >= lo && cyc <= hi);
            set_entry(first + idx);
            in_valid = 1'b1;
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        chk("stream_all_sent", idx, count);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 30 && q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic flush_with_7();
        flush     = 1'b1;
        out_ready = 1'b1;
        set_entry(7);
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid_low", out_valid, 0);
        chk("flush_ctrl_zero", out_ctrl, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : driver
        int cyc;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_fields", {out_ctrl, out_addr, out_data}, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single entry with known fields, downstream always ready.
        out_ready = 1'b1;
        in_ctrl   = 4'b1010;
        in_addr   = 5'd7;
        in_data   = {32'h0000_0011, 32'hDEAD_BEEF};
        send_cur();
        chk("single_valid", out_valid, 1);
        chk("single_fields", {out_ctrl, out_addr, out_data},
            {4'b1010, 5'd7, 32'h0000_0011, 32'hDEAD_BEEF});
        @(posedge clk);
        #1;
        chk("single_then_empty", out_valid, 0);

        // Unaccepted cycle with all control bits set: output must stay a bubble.
        in_ctrl = 4'b1111;
        @(posedge clk);
        #1;
        chk("idle_ctrl_zero", out_ctrl, 0);

        // Eight entries with a three-cycle downstream stall.
        stream(1, 8, 3, 5, cyc);
        drain();

        // Flush with a full stage and a competing input.
        out_ready = 1'b0;
        set_entry(5);
        send_cur();
`ifdef PIPE_STAGE_SKID_EN
        set_entry(6);
        send_cur();
`endif
        flush_with_7();
        // Flush with one stored entry, where the input would otherwise be taken.
        out_ready = 1'b0;
        set_entry(5);
        send_cur();
        flush_with_7();

        // Back-to-back throughput.
        stream(0, 16, 1000, 1000, cyc);
        chk("b2b_cycles", cyc, 16);
        drain();

        // Asynchronous reset between edges while holding entries.
        out_ready = 1'b0;
        set_entry(20);
        send_cur();
`ifdef PIPE_STAGE_SKID_EN
        set_entry(21);
        send_cur();
`endif
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_fields", {out_ctrl, out_addr, out_data}, 0);
        chk("async_rst_ready", in_ready, 1);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        set_entry(9);
        send_cur();
        chk("post_rst_first", {out_ctrl, out_addr, out_data},
            {4'd9, 5'd9 ^ 5'h15, 32'h109, 32'd9});
        drain();

        repeat (2) @(posedge clk);
        #1;
        chk("final_queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
